key_repeat_pad: RTL and testbench

Multi-channel debouncer with auto-repeat for the game's push-button inputs. Each raw switch is synchronised to `clk` and debounced in both directions, producing a stable level, press/release strobes and a typematic repeat strobe. It sits between the board buttons and the game controller so that holding left/right/down moves a piece at a fixed rate without extra logic downstream.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_repeat_channel.sv | 166 ++++++++++++++++
 rtl/key_repeat_pad.sv | 42 ++++
 tb/tb_key_repeat_pad.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button debounce/auto-repeat block.
// Delays are expressed in 800x525 video frames.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD_FIRST   = 3'd2,
        ST_HELD_REPEAT  = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } key_state_t;

    localparam int FRAME_CYCLES         = 800 * 525;
    localparam int HOLD_FRAMES          = 1;
    localparam int REPEAT_START_FRAMES  = 20;
    localparam int REPEAT_PERIOD_FRAMES = 6;

    localparam int DEF_HOLD_DELAY    = FRAME_CYCLES * HOLD_FRAMES;
    localparam int DEF_REPEAT_START  = FRAME_CYCLES * REPEAT_START_FRAMES;
    localparam int DEF_REPEAT_PERIOD = FRAME_CYCLES * REPEAT_PERIOD_FRAMES;

endpackage

// File: rtl/key_repeat_channel.sv
// One key channel: 2-flop synchroniser, debounce/repeat FSM with a shared counter,
// and registered level/strobe outputs.
module key_repeat_channel
    import key_pkg::*;
#(
    parameter int HOLD_DELAY    = DEF_HOLD_DELAY,
    parameter int REPEAT_START  = DEF_REPEAT_START,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_sw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat,
    output logic key_fire
);

    // IDLE: up | PRESS_WAIT: debounce press | HELD_FIRST: wait first repeat
    // HELD_REPEAT: periodic repeat | RELEASE_WAIT: debounce release (level still 1)

    localparam logic [CNT_W-1:0] L_ZERO = '0;
    localparam logic [CNT_W-1:0] L_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(HOLD_DELAY);
    localparam logic [CNT_W-1:0] L_RS   = CNT_W'(REPEAT_START);
    localparam logic [CNT_W-1:0] L_RP   = CNT_W'(REPEAT_PERIOD);

    logic             r_sync1, r_sync2;
    key_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_press, w_release, w_repeat;
    logic             r_evt_press, r_evt_release, r_evt_repeat;
    logic             r_level, r_press, r_release, r_repeat, r_fire;
    logic             w_s;

    assign w_s       = r_sync2;
    assign w_cnt_inc = r_cnt + L_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = L_ZERO;
                if (w_s) begin
                    if (HOLD_DELAY == 1) begin
                        w_state_nxt = ST_HELD_FIRST;
                        w_press     = 1'b1;
                    end else begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = L_ONE;
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = L_ZERO;
                end else if (w_cnt_inc == L_HOLD) begin
                    w_state_nxt = ST_HELD_FIRST;
                    w_cnt_nxt   = L_ZERO;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_HELD_FIRST, ST_HELD_REPEAT: begin
                if (!w_s) begin
                    // a single-sample hold accepts the release immediately
                    if (HOLD_DELAY == 1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = L_ZERO;
                        w_release   = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = L_ONE;
                    end
                end else if (r_state == ST_HELD_REPEAT) begin
                    if (w_cnt_inc == L_RP) begin
                        w_cnt_nxt = L_ZERO;
                        w_repeat  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (REPEAT_EN) begin
                    if (w_cnt_inc == L_RS) begin
                        w_state_nxt = ST_HELD_REPEAT;
                        w_cnt_nxt   = L_ZERO;
                        w_repeat    = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = ST_HELD_FIRST;
                    w_cnt_nxt   = L_ZERO;
                end else if (w_cnt_inc == L_HOLD) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = L_ZERO;
                    w_release   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = L_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_state       <= ST_IDLE;
            r_cnt         <= L_ZERO;
            r_evt_press   <= 1'b0;
            r_evt_release <= 1'b0;
            r_evt_repeat  <= 1'b0;
        end else begin
            r_sync1       <= key_sw;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_evt_press   <= w_press;
            r_evt_release <= w_release;
            r_evt_repeat  <= w_repeat;
        end
    end

    // Output stage follows the FSM by one cycle so level and strobes line up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_fire    <= 1'b0;
        end else begin
            r_level   <= (r_state == ST_HELD_FIRST) || (r_state == ST_HELD_REPEAT) ||
                         (r_state == ST_RELEASE_WAIT);
            r_press   <= r_evt_press;
            r_release <= r_evt_release;
            r_repeat  <= r_evt_repeat;
            r_fire    <= r_evt_press | r_evt_repeat;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_repeat  = r_repeat;
    assign key_fire    = r_fire;

endmodule

// File: rtl/key_repeat_pad.sv
// Multi-channel push-button debouncer with typematic auto-repeat.
// Each key is handled by an independent key_repeat_channel instance.
module key_repeat_pad
    import key_pkg::*;
#(
    parameter int                N_KEYS        = 4,
    parameter int                HOLD_DELAY    = DEF_HOLD_DELAY,
    parameter int                REPEAT_START  = DEF_REPEAT_START,
    parameter int                REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter logic [N_KEYS-1:0] REPEAT_EN     = '1,
    parameter int                CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_sw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic [N_KEYS-1:0] key_fire
);

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_repeat_channel #(
            .HOLD_DELAY    (HOLD_DELAY),
            .REPEAT_START  (REPEAT_START),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_EN[gi]),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_sw      (key_sw[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi]),
            .key_repeat  (key_repeat[gi]),
            .key_fire    (key_fire[gi])
        );
    end

endmodule

// File: tb/tb_key_repeat_pad.sv
// Directed bench for key_repeat_pad with short delays (hold 4, start 10, period 3).
module tb_key_repeat_pad;

    logic       clk;
    logic       rst_n;
    logic [1:0] key_sw;
    logic [1:0] key_level, key_press, key_release, key_repeat, key_fire;

    int n_checks;
    int n_pass;

    key_repeat_pad #(
        .N_KEYS        (2),
        .HOLD_DELAY    (4),
        .REPEAT_START  (10),
        .REPEAT_PERIOD (3),
        .REPEAT_EN     (2'b01),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_sw      (key_sw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .key_fire    (key_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and sample 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key_sw = 2'b00;
        rst_n  = 1'b0;
        tick();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        key_sw = 2'b11;
        rst_n  = 1'b0;
        tick();
        n_checks++;
        if ({key_level, key_press, key_release, key_repeat, key_fire} !== 10'b0)
            $display("FAIL reset outputs=%b exp=0",
                     {key_level, key_press, key_release, key_repeat, key_fire});
        else n_pass++;
        key_sw = 2'b00;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_clean_press();
        logic [1:0] e_press, e_rep, e_lvl, e_rel;
        do_reset();
        key_sw = 2'b01;
        for (int k = 0; k <= 24; k++) begin
            tick();
            e_press = {1'b0, k == 6};
            e_rep   = {1'b0, (k == 16) || (k == 19) || (k == 22)};
            e_lvl   = {1'b0, k >= 6};
            n_checks++;
            if (key_press !== e_press || key_repeat !== e_rep || key_fire !== (e_press | e_rep) ||
                key_level !== e_lvl || key_release !== 2'b00)
                $display("FAIL clean_press k=%0d press=%b rep=%b fire=%b lvl=%b rel=%b exp press=%b rep=%b lvl=%b",
                         k, key_press, key_repeat, key_fire, key_level, key_release, e_press, e_rep, e_lvl);
            else n_pass++;
        end
        key_sw = 2'b00;
        for (int k = 0; k <= 9; k++) begin
            tick();
            e_rep = {1'b0, k == 0};
            e_rel = {1'b0, k == 6};
            e_lvl = {1'b0, k < 6};
            n_checks++;
            if (key_release !== e_rel || key_level !== e_lvl || key_repeat !== e_rep ||
                key_press !== 2'b00)
                $display("FAIL clean_release k=%0d rel=%b lvl=%b rep=%b press=%b exp rel=%b lvl=%b rep=%b",
                         k, key_release, key_level, key_repeat, key_press, e_rel, e_lvl, e_rep);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int pat [0:6] = '{1, 1, 0, 1, 1, 1, 1};
        int presses = 0;
        do_reset();
        for (int k = 0; k <= 15; k++) begin
            key_sw[0] = (k <= 6) ? pat[k][0] : 1'b1;
            tick();
            if (key_press[0]) presses++;
            n_checks++;
            if (key_press[0] !== (k == 9) || key_level[0] !== (k >= 9))
                $display("FAIL bounce k=%0d press=%b lvl=%b exp press=%b lvl=%b",
                         k, key_press[0], key_level[0], k == 9, k >= 9);
            else n_pass++;
        end
        n_checks++;
        if (presses !== 1) $display("FAIL bounce_count presses=%0d exp=1", presses);
        else n_pass++;
    endtask

    task automatic test_release_glitch();
        logic e_rel, e_rep, e_lvl;
        do_reset();
        key_sw = 2'b01;
        repeat (12) tick();
        for (int k = 0; k <= 27; k++) begin
            key_sw[0] = (k < 2) ? 1'b0 : (k < 18) ? 1'b1 : 1'b0;
            tick();
            e_rel = (k == 24);
            e_rep = (k == 15) || (k == 18);
            e_lvl = (k < 24);
            n_checks++;
            if (key_release[0] !== e_rel || key_repeat[0] !== e_rep || key_level[0] !== e_lvl ||
                key_press[0] !== 1'b0)
                $display("FAIL release_glitch k=%0d rel=%b rep=%b lvl=%b press=%b exp rel=%b rep=%b lvl=%b",
                         k, key_release[0], key_repeat[0], key_level[0], key_press[0], e_rel, e_rep, e_lvl);
            else n_pass++;
        end
    endtask

    task automatic test_repeat_disabled();
        int presses = 0;
        int repeats = 0;
        do_reset();
        key_sw = 2'b10;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (key_press[1]) presses++;
            if (key_repeat[1]) repeats++;
            n_checks++;
            if (key_press !== {k == 6, 1'b0} || key_repeat !== 2'b00 || key_level !== {k >= 6, 1'b0})
                $display("FAIL repeat_disabled k=%0d press=%b rep=%b lvl=%b", k, key_press, key_repeat, key_level);
            else n_pass++;
        end
        n_checks++;
        if (presses !== 1 || repeats !== 0)
            $display("FAIL repeat_disabled_count presses=%0d repeats=%0d exp 1/0", presses, repeats);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        key_sw = 2'b11;
        for (int k = 0; k <= 8; k++) begin
            tick();
            n_checks++;
            if (key_press !== ((k == 6) ? 2'b11 : 2'b00) || key_fire !== ((k == 6) ? 2'b11 : 2'b00))
                $display("FAIL simultaneous k=%0d press=%b fire=%b exp=%b",
                         k, key_press, key_fire, (k == 6) ? 2'b11 : 2'b00);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        key_sw = 2'b01;
        repeat (20) tick();
        n_checks++;
        if (key_level[0] !== 1'b1) $display("FAIL mid_hold_pre lvl=%b exp=1", key_level[0]);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({key_level, key_press, key_release, key_repeat, key_fire} !== 10'b0)
            $display("FAIL mid_hold_reset outputs=%b exp=0",
                     {key_level, key_press, key_release, key_repeat, key_fire});
        else n_pass++;
        rst_n = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            tick();
            n_checks++;
            if (key_release !== 2'b00 || key_press[0] !== (k == 6) || key_level[0] !== (k >= 6))
                $display("FAIL mid_hold_after k=%0d rel=%b press=%b lvl=%b exp press=%b lvl=%b",
                         k, key_release, key_press[0], key_level[0], k == 6, k >= 6);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        key_sw   = 2'b00;
        rst_n    = 1'b0;
        tick();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_repeat_disabled();
        test_simultaneous();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
